// File: rtl/ds_noise_shaper_mc_if.sv
// Frame request and per-channel result bus for the multi-channel delta-sigma noise shaper.
// The master drives frames in and the slave returns one result per channel.
interface ds_noise_shaper_mc_if #(
  parameter int IN_BITS          = 16,
  parameter int FRAC_BITS        = 11,
  parameter int OUT_BITS         = 7,
  parameter int NUM_CH           = 2,
  parameter int SHIFT_COUNT_BITS = 4
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_CH*IN_BITS-1:0]   u;
  logic [SHIFT_COUNT_BITS-1:0] u_rshift;
  logic [2:0]                  order;
  logic                        hist_clear;
  logic                        y_valid;
  logic [CH_BITS-1:0]          y_ch;
  logic [OUT_BITS-1:0]         y;
  logic                        y_clip;
  logic                        force_err;
  logic [FRAC_BITS-1:0]        forced_err_value;

  modport master (
    output in_valid, u, u_rshift, order, hist_clear, force_err, forced_err_value,
    input  in_ready, y_valid, y_ch, y, y_clip
  );

  modport slave (
    input  in_valid, u, u_rshift, order, hist_clear, force_err, forced_err_value,
    output in_ready, y_valid, y_ch, y, y_clip
  );
endinterface

// File: rtl/ds_noise_shaper_mc.sv
// Multi-channel error-feedback delta-sigma modulator, NTF (1-z^-1)^order, with one shared
// shift-add accumulator stepped over taps and channels.
module ds_noise_shaper_mc #(
  parameter int IN_BITS          = 16,
  parameter int FRAC_BITS        = 11,
  parameter int OUT_BITS         = 7,
  parameter int NUM_CH           = 2,
  parameter int MAX_ORDER        = 4,
  parameter int SHIFT_COUNT_BITS = 4
) (
  input logic                  clk,
  input logic                  reset,
  ds_noise_shaper_mc_if.slave  bus
);
  localparam int ACC_W   = IN_BITS + 2;
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_BITS-1:0]   LAST_CH   = CH_BITS'(NUM_CH - 1);
  localparam logic [2:0]           MAX_ORD3  = 3'(MAX_ORDER);
  localparam logic [FRAC_BITS-1:0] ERR_FLIP  = {1'b1, {(FRAC_BITS-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] TAP  = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  logic [1:0]                  state;
  logic [CH_BITS-1:0]          ch;
  logic [2:0]                  tap_idx;
  logic [NUM_CH*IN_BITS-1:0]   u_r;
  logic [SHIFT_COUNT_BITS-1:0] rshift_r;
  logic [2:0]                  order_r;
  logic signed [ACC_W-1:0]     acc;

  logic [OUT_BITS-1:0]         y_r;
  logic [CH_BITS-1:0]          y_ch_r;
  logic                        y_valid_r;
  logic                        y_clip_r;

  // hist[c][j] holds e[c][j+1]
  logic signed [FRAC_BITS-1:0] hist [NUM_CH][MAX_ORDER];

  logic [2:0]                  order_clamped;
  logic [IN_BITS-1:0]          u_sel;
  logic signed [ACC_W-1:0]     load_val;
  logic                        tap_neg;
  logic [2:0]                  tap_k;
  logic [1:0]                  tap_sh;
  logic                        last_tap;
  logic signed [FRAC_BITS-1:0] e_sel;
  logic signed [ACC_W-1:0]     term;
  logic signed [ACC_W-1:0]     acc_next;
  logic [OUT_BITS-1:0]         y_raw;
  logic [FRAC_BITS-1:0]        err_val;

  assign bus.in_ready = (state == IDLE) && !reset;
  assign bus.y_valid  = y_valid_r;
  assign bus.y_ch     = y_ch_r;
  assign bus.y        = y_r;
  assign bus.y_clip   = y_clip_r;

  assign order_clamped = (bus.order > MAX_ORD3) ? MAX_ORD3 : bus.order;
  assign u_sel         = u_r[ch*IN_BITS +: IN_BITS];
  assign load_val      = $signed({2'b00, u_sel}) >>> rshift_r;
  assign y_raw         = acc[ACC_W-1:FRAC_BITS];
  assign err_val       = acc[FRAC_BITS-1:0] ^ ERR_FLIP;

  // Binomial feedback coefficients factored into power-of-two shifts so each cycle is one shift-add.
  always_comb begin
    tap_neg  = 1'b0;
    tap_k    = 3'd1;
    tap_sh   = 2'd0;
    last_tap = 1'b1;
    case (order_r)
      3'd2: begin
        case (tap_idx)
          3'd0:    begin tap_sh = 2'd1; last_tap = 1'b0; end
          default: begin tap_neg = 1'b1; tap_k = 3'd2; end
        endcase
      end
      3'd3: begin
        last_tap = 1'b0;
        case (tap_idx)
          3'd0:    tap_sh = 2'd1;
          3'd1:    tap_sh = 2'd0;
          3'd2:    begin tap_neg = 1'b1; tap_k = 3'd2; tap_sh = 2'd1; end
          3'd3:    begin tap_neg = 1'b1; tap_k = 3'd2; end
          default: begin tap_k = 3'd3; last_tap = 1'b1; end
        endcase
      end
      3'd4: begin
        last_tap = 1'b0;
        case (tap_idx)
          3'd0:    tap_sh = 2'd2;
          3'd1:    begin tap_neg = 1'b1; tap_k = 3'd2; tap_sh = 2'd2; end
          3'd2:    begin tap_neg = 1'b1; tap_k = 3'd2; tap_sh = 2'd1; end
          3'd3:    begin tap_k = 3'd3; tap_sh = 2'd2; end
          default: begin tap_neg = 1'b1; tap_k = 3'd4; last_tap = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    e_sel = '0;
    for (int unsigned j = 0; j < MAX_ORDER; j++) begin
      if (tap_k == 3'(j + 1)) e_sel = hist[ch][j];
    end
    term     = {{(ACC_W-FRAC_BITS){e_sel[FRAC_BITS-1]}}, e_sel} <<< tap_sh;
    acc_next = tap_neg ? (acc - term) : (acc + term);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= '0;
      tap_idx   <= '0;
      u_r       <= '0;
      rshift_r  <= '0;
      order_r   <= '0;
      acc       <= '0;
      y_r       <= '0;
      y_ch_r    <= '0;
      y_valid_r <= 1'b0;
      y_clip_r  <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            u_r      <= bus.u;
            rshift_r <= bus.u_rshift;
            order_r  <= order_clamped;
            ch       <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          acc     <= load_val;
          tap_idx <= '0;
          state   <= (order_r == 3'd0) ? EMIT : TAP;
        end
        TAP: begin
          acc     <= acc_next;
          tap_idx <= tap_idx + 3'd1;
          if (last_tap) state <= EMIT;
        end
        EMIT: begin
          y_valid_r <= 1'b1;
          y_ch_r    <= ch;
          y_clip_r  <= acc[ACC_W-1];
          y_r       <= acc[ACC_W-1] ? '0 : y_raw;
          if (ch == LAST_CH) begin
            state <= IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && !bus.in_valid && bus.hist_clear)) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned j = 0; j < MAX_ORDER; j++) hist[c][j] <= '0;
      end
    end else if (state == EMIT) begin
      for (int unsigned j = MAX_ORDER - 1; j >= 1; j--) hist[ch][j] <= hist[ch][j-1];
      hist[ch][0] <= bus.force_err ? bus.forced_err_value : err_val;
    end
  end
endmodule

// File: tb/tb_ds_noise_shaper_mc.sv
// Randomized and directed bench for ds_noise_shaper_mc against a binomial-NTF reference model.
module tb_ds_noise_shaper_mc;
  localparam int IN_BITS   = 16;
  localparam int FRAC_BITS = 11;
  localparam int OUT_BITS  = 7;
  localparam int NUM_CH    = 2;
  localparam int MAX_ORDER = 4;
  localparam int SCB       = 4;
  localparam int LSB_W     = 1 << FRAC_BITS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ds_noise_shaper_mc_if #(.IN_BITS(IN_BITS), .FRAC_BITS(FRAC_BITS), .OUT_BITS(OUT_BITS),
                          .NUM_CH(NUM_CH), .SHIFT_COUNT_BITS(SCB)) bus ();

  ds_noise_shaper_mc #(.IN_BITS(IN_BITS), .FRAC_BITS(FRAC_BITS), .OUT_BITS(OUT_BITS),
                       .NUM_CH(NUM_CH), .MAX_ORDER(MAX_ORDER), .SHIFT_COUNT_BITS(SCB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int e_m [NUM_CH][1:MAX_ORDER];
  int cnt_tab [5] = '{2, 3, 4, 7, 7};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 1; k <= MAX_ORDER; k++) e_m[c][k] = 0;
  endtask

  // Feedback H = 1 - (1-z^-1)^n: coefficient of e_k is (-1)^(k+1) * C(n,k).
  task automatic model_chan(input int c, input int uval, input int rs, input int ord,
                            input int fe, input int fv, output int y_e, output int clip_e);
    int acc, r;
    acc = uval >> rs;
    for (int k = 1; k <= ord; k++)
      acc += ((k % 2) ? 1 : -1) * binom(ord, k) * e_m[c][k];
    r = acc % LSB_W;
    if (r < 0) r += LSB_W;
    y_e    = (acc < 0) ? 0 : acc / LSB_W;
    clip_e = (acc < 0) ? 1 : 0;
    for (int k = MAX_ORDER; k >= 2; k--) e_m[c][k] = e_m[c][k-1];
    e_m[c][1] = fe ? fv : (r - LSB_W / 2);
  endtask

  task automatic do_frame(input int u0, input int u1, input int rs, input int ord, input bit jitter);
    int ordc, cnt, total, waitc, c_exp, fe, fv;
    int ye [NUM_CH];
    int ce [NUM_CH];
    int uv [NUM_CH];
    logic [IN_BITS-1:0] ua, ub;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    ordc  = (ord > MAX_ORDER) ? MAX_ORDER : ord;
    fe    = int'(bus.force_err);
    fv    = int'($signed(bus.forced_err_value));
    ua    = u0[IN_BITS-1:0];
    ub    = u1[IN_BITS-1:0];
    uv[0] = int'(ua);
    uv[1] = int'(ub);
    for (int c = 0; c < NUM_CH; c++) model_chan(c, uv[c], rs, ordc, fe, fv, ye[c], ce[c]);
    cnt   = cnt_tab[ordc];
    total = cnt * NUM_CH;
    bus.in_valid = 1'b1;
    bus.u        = {ub, ua};
    bus.u_rshift = rs[SCB-1:0];
    bus.order    = ord[2:0];
    @(negedge clk);
    check_eq("ready_after_capture", int'(bus.in_ready), 0);
    for (int k = 1; k <= total; k++) begin
      if (jitter) begin
        bus.u          = {$urandom, $urandom};
        bus.order      = 3'($urandom);
        bus.u_rshift   = SCB'($urandom);
        bus.hist_clear = 1'($urandom);
      end
      @(negedge clk);
      c_exp = (k % cnt == 0) ? (k / cnt - 1) : -1;
      check_eq($sformatf("y_valid k%0d", k), int'(bus.y_valid), (c_exp >= 0) ? 1 : 0);
      if (c_exp >= 0) begin
        check_eq("y_ch", int'(bus.y_ch), c_exp);
        check_eq($sformatf("y ch%0d ord%0d", c_exp, ordc), int'(bus.y), ye[c_exp]);
        check_eq($sformatf("y_clip ch%0d", c_exp), int'(bus.y_clip), ce[c_exp]);
      end
      check_eq($sformatf("in_ready k%0d", k), int'(bus.in_ready), (k == total) ? 1 : 0);
    end
    bus.in_valid   = 1'b0;
    bus.hist_clear = 1'b0;
  endtask

  task automatic idle_clear();
    @(negedge clk);
    bus.hist_clear = 1'b1;
    @(negedge clk);
    bus.hist_clear = 1'b0;
    clear_model();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.u = '0;
    bus.u_rshift = '0;
    bus.order = '0;
    bus.hist_clear = 1'b0;
    bus.force_err = 1'b0;
    bus.forced_err_value = '0;
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check_eq("ready_in_reset", int'(bus.in_ready), 0);
    end
    check_eq("reset_y", int'(bus.y), 0);
    check_eq("reset_y_ch", int'(bus.y_ch), 0);
    check_eq("reset_y_valid", int'(bus.y_valid), 0);
    check_eq("reset_y_clip", int'(bus.y_clip), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", int'(bus.in_ready), 1);

    // Order 1 alternation on ch0, zero input on ch1, back to back.
    for (int f = 0; f < 4; f++) do_frame(32'h8000, 0, 0, 1, 1'b0);

    // Order 0 with full-scale input shifted by 4, then order 1 exposes the stored error.
    idle_clear();
    do_frame(32'hFFFF, 32'hFFFF, 4, 0, 1'b0);
    do_frame(0, 0, 0, 1, 1'b0);

    // Forced unit error through the order-4 schedule.
    idle_clear();
    bus.force_err = 1'b1;
    bus.forced_err_value = 11'd1;
    for (int f = 0; f < 5; f++) do_frame(0, 0, 0, 4, 1'b0);
    bus.force_err = 1'b0;

    // Busy-time input churn (including hist_clear) must be ignored; then a real clear.
    for (int f = 0; f < 4; f++) do_frame(int'($urandom), int'($urandom), 0, 2, 1'b1);
    idle_clear();
    do_frame(32'h8000, 32'h8000, 0, 2, 1'b0);

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) idle_clear();
      do_frame(int'($urandom), int'($urandom), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 7)), 1'($urandom));
    end

    // Reset during channel 1 taps of an order-3 frame.
    while (!bus.in_ready) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.u = {16'h1234, 16'h8000};
    bus.order = 3'd3;
    bus.u_rshift = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_y_valid", int'(bus.y_valid), 0);
      check_eq("abort_ready", int'(bus.in_ready), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", int'(bus.in_ready), 1);
    check_eq("abort_y", int'(bus.y), 0);
    check_eq("abort_y_ch", int'(bus.y_ch), 0);
    check_eq("abort_y_clip", int'(bus.y_clip), 0);
    repeat (6) begin
      @(negedge clk);
      check_eq("abort_no_result", int'(bus.y_valid), 0);
    end
    clear_model();
    for (int f = 0; f < 3; f++) do_frame(32'h8000, 0, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ds_noise_shaper_mc.md
Name: ds_noise_shaper_mc

Overview:
- Multi-channel, runtime-order-selectable delta-sigma modulator for the noise-shaping DAC.
- Quantises NUM_CH unsigned IN_BITS samples per frame to OUT_BITS codes, with error feedback NTF (1-z^-1)^order, order 0..MAX_ORDER.
- Uses one shared shift-add datapath, time-multiplexed over taps and channels.
- Feeds per-channel PWM stages; a frame is requested with a valid/ready handshake.

Parameters:
- IN_BITS, 16, input sample width (unsigned).
- FRAC_BITS, 11, bits below the output LSB.
- OUT_BITS, 7, output width; must equal IN_BITS+2-FRAC_BITS.
- NUM_CH, 2, channels per frame.
- MAX_ORDER, 4, highest supported NTF order; legal range 1..4.
- SHIFT_COUNT_BITS, 4, width of u_rshift.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  frame available
- in_ready  out  1  high only in IDLE
- u  in  NUM_CH*IN_BITS  packed samples, channel 0 in LSBs
- u_rshift  in  SHIFT_COUNT_BITS  arithmetic right shift applied to every u
- order  in  3  NTF order; values above MAX_ORDER are treated as MAX_ORDER
- hist_clear  in  1  clears all error histories; honoured in IDLE only
- y_valid  out  1  one-cycle pulse per channel result
- y_ch  out  $clog2(NUM_CH) (min 1)  channel index of y
- y  out  OUT_BITS  quantised code
- y_clip  out  1  y clamped this result
- force_err  in  1  test: store forced_err_value instead of the computed error
- forced_err_value  in  FRAC_BITS  signed forced error

Behaviour:
- Reset:
  - State IDLE; all histories e[c][1..MAX_ORDER] = 0.
  - y=0, y_ch=0, y_valid=0, y_clip=0.
  - in_ready=0 during reset cycles, 1 on the first cycle after.
  - Reset mid-frame aborts the frame; no further y_valid is produced.
- States: IDLE, LOAD, TAP, EMIT.
  - IDLE: if in_valid && in_ready, capture u, u_rshift and clamped order into frame registers; ch=0; go to LOAD. Otherwise, hist_clear=1 zeroes all histories.
  - LOAD: acc = zero-extended u[ch] >>> u_rshift.
  - TAP: one shift-add per cycle: acc += (±e[ch][k] << s).
  - EMIT: register outputs. If ch < NUM_CH-1, ch++ and go to LOAD; else go to IDLE.
- Inputs (u, u_rshift, order) are ignored outside IDLE; changes mid-frame have no effect.
- Tap schedule per order (terms in order):
  - order 0: none.
  - order 1: +e1.
  - order 2: +2e1, -e2.
  - order 3: +2e1, +e1, -2e2, -e2, +e3.
  - order 4: +4e1, -4e2, -2e2, +4e3, -e4.
- Per-channel cycle count = LOAD + number of terms + EMIT:
  - order 0: 2
  - order 1: 3
  - order 2: 4
  - order 3: 7
  - order 4: 7
- Frame latency = NUM_CH × per-channel count.
- in_ready returns on the cycle after the last EMIT.
- acc width: IN_BITS+2 signed, two's complement; default range cannot overflow.
- Quantiser:
  - y_raw = acc[IN_BITS+1:FRAC_BITS].
  - err = acc[FRAC_BITS-1:0] XOR (1<<(FRAC_BITS-1)), signed.
  - If acc < 0: y=0 and y_clip=1; else y=y_raw and y_clip=0.
  - err is always taken from the unclamped acc.
- History update at EMIT: e[ch][k] <= e[ch][k-1] for k = MAX_ORDER..2; e[ch][1] <= err, or forced_err_value when force_err=1.
- Histories of other channels are untouched.
- Histories persist across order changes.
- Outputs y, y_ch, y_clip are registered and hold their values until the next EMIT; y_valid is high exactly one cycle per channel.

Test Plan:
- Order 1, NUM_CH=1, u=0x8000, rshift 0, back-to-back frames -> y = 16,15,16,15…; y_clip=0; each frame 3 cycles after capture.
- u=0xFFFF, rshift 4, order 0, history 0 -> y=1, stored err=+1023; output 2 cycles after capture.
- Order 4, force_err=1, forced_err_value=1, u=0, five frames -> acc = 0,4,-2,2,1; y=0 throughout; y_clip=0,0,1,0,0.
- NUM_CH=2, ch0 u=0x8000, ch1 u=0, order 1 -> y_ch 0 then 1 per frame; ch0 gives 16,15,…, ch1 gives 0 with independent history; in_valid held high while busy is not accepted until in_ready.
- Reset asserted mid-TAP of channel 1 -> no y_valid for ch1; y=0; in_ready=1 one cycle after release; next frame behaves as from power-up.
- hist_clear pulsed in IDLE after frames with non-zero history -> next order-2 frame with u=0x8000 gives y=16 (zero feedback); hist_clear asserted while busy is ignored.
